// File: rtl/uart_stim_tx.sv
// Stimulus-side UART transmitter: a small byte FIFO feeding an 8-bit LSB-first
// async framer with optional parity and one or two stop bits.
module uart_stim_tx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_STP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          par_r;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic          full, push, pop, bit_end, last_stop;
  logic [7:0]    head;

  // Fullness comes from the registered level only, so a same-edge pop never frees a slot.
  assign full      = (level == (AW+1)'(FIFO_DEPTH));
  assign wr_ready  = !full;
  assign push      = wr_valid && !full;
  assign bit_end   = (cnt == '0);
  assign last_stop = (idx == LAST_STP);
  assign head      = mem[rptr];
  assign pop       = (level != '0) &&
                     ((state == IDLE) || (state == STOP && bit_end && last_stop));
  assign busy       = (state != IDLE) || (level != '0);
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
      // A fresh overflow wins over a same-cycle clear.
      if (wr_valid && full)  overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      par_r      <= 1'b0;
      tx_o       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (pop) begin
            shift <= head;
            par_r <= (PARITY == 1) ? ~^head : ^head;
            cnt   <= CNT_MAX;
            tx_o  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= CNT_MAX;
            idx   <= '0;
            tx_o  <= shift[0];
            state <= DATA;
          end else cnt <= cnt - 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            cnt <= CNT_MAX;
            if (idx == 3'd7) begin
              idx <= '0;
              if (PARITY != 0) begin
                tx_o  <= par_r;
                state <= PAR;
              end else begin
                tx_o  <= 1'b1;
                state <= STOP;
              end
            end else begin
              idx   <= idx + 1'b1;
              tx_o  <= shift[1];
              shift <= {1'b0, shift[7:1]};
            end
          end else cnt <= cnt - 1'b1;
        end
        PAR: begin
          if (bit_end) begin
            cnt   <= CNT_MAX;
            idx   <= '0;
            tx_o  <= 1'b1;
            state <= STOP;
          end else cnt <= cnt - 1'b1;
        end
        STOP: begin
          // Registered pulse lands on the final cycle of the last stop bit.
          if (last_stop && cnt == CW'(1)) frame_done <= 1'b1;
          if (bit_end) begin
            cnt <= CNT_MAX;
            if (!last_stop) begin
              idx <= idx + 1'b1;
            end else if (pop) begin
              shift <= head;
              par_r <= (PARITY == 1) ? ~^head : ^head;
              idx   <= '0;
              tx_o  <= 1'b0;
              state <= START;
            end else begin
              idx   <= '0;
              tx_o  <= 1'b1;
              state <= IDLE;
            end
          end else cnt <= cnt - 1'b1;
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx: five parameter variants, a byte scoreboard and a
// mid-bit sampling receiver on the currently selected instance.
module tb_uart_stim_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wd = '0;
  logic [4:0] wv = '0;
  logic       ovc = 1'b0;
  logic [4:0] tx, rdy, bsy, fd, ovf;
  logic [2:0] lv0;
  logic [4:0] lv1, lv2, lv3, lv4;

  int cyc = 0;
  int sel = 1;
  int n_chk = 0;
  int n_pass = 0;
  int fd_all = 0;
  logic tx_s, fd_s;
  logic [7:0] exp_q[$];
  int fd_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    tx_s = tx[sel];
    fd_s = fd[sel];
  end

  always @(negedge clk) begin
    if (fd_s === 1'b1) fd_q.push_back(cyc);
    if (|fd) fd_all = fd_all + 1;
  end

  // 0: BAUD 4, depth 4 | 1: defaults | 2: even parity | 3: odd parity, 2 stop | 4: BAUD 8
  uart_stim_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv[0]), .wr_data(wd), .wr_ready(rdy[0]),
    .tx_o(tx[0]), .busy(bsy[0]), .fifo_level(lv0), .frame_done(fd[0]),
    .overflow(ovf[0]), .overflow_clr(ovc));
  uart_stim_tx u_def (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv[1]), .wr_data(wd), .wr_ready(rdy[1]),
    .tx_o(tx[1]), .busy(bsy[1]), .fifo_level(lv1), .frame_done(fd[1]),
    .overflow(ovf[1]), .overflow_clr(ovc));
  uart_stim_tx #(.BAUD_DIV(4), .PARITY(2)) u_pe (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv[2]), .wr_data(wd), .wr_ready(rdy[2]),
    .tx_o(tx[2]), .busy(bsy[2]), .fifo_level(lv2), .frame_done(fd[2]),
    .overflow(ovf[2]), .overflow_clr(ovc));
  uart_stim_tx #(.BAUD_DIV(4), .PARITY(1), .STOP_BITS(2)) u_po (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv[3]), .wr_data(wd), .wr_ready(rdy[3]),
    .tx_o(tx[3]), .busy(bsy[3]), .fifo_level(lv3), .frame_done(fd[3]),
    .overflow(ovf[3]), .overflow_clr(ovc));
  uart_stim_tx #(.BAUD_DIV(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv[4]), .wr_data(wd), .wr_ready(rdy[4]),
    .tx_o(tx[4]), .busy(bsy[4]), .fifo_level(lv4), .frame_done(fd[4]),
    .overflow(ovf[4]), .overflow_clr(ovc));

  task automatic wr(input int inst, input logic [7:0] b, input bit accept);
    @(negedge clk);
    wd = b;
    wv = '0;
    wv[inst] = 1'b1;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic wr_end();
    @(negedge clk);
    wv = '0;
  endtask

  // Waits (bounded) for a start bit, then samples nb bits at their midpoints.
  task automatic rx_frame(input int bd, input int nb, output logic [11:0] bits,
                          output int s, output bit ok);
    int i;
    ok = 1'b0; bits = '1; s = 0; i = 0;
    while (!ok && i < 40 * bd + 200) begin
      @(negedge clk);
      if (tx_s === 1'b0) ok = 1'b1;
      i++;
    end
    if (ok) begin
      s = cyc;
      repeat (bd / 2) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
        bits[k] = tx_s;
        if (k < nb - 1) repeat (bd) @(negedge clk);
      end
    end
  endtask

  task automatic sb_check(input string name, input logic [7:0] got);
    logic [7:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got %02h, scoreboard empty", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) $display("FAIL %s: got %02h want %02h", name, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    int bad_tx, bad_st;
    sel = 1;
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++;
    if ({tx, rdy, bsy} !== {5'h1f, 5'h1f, 5'h00}) $display("FAIL reset_outs: tx=%b rdy=%b busy=%b want 11111/11111/00000", tx, rdy, bsy);
    else n_pass++;
    n_chk++;
    if ({lv0, lv1, ovf, fd} !== '0) $display("FAIL reset_zero: lv0=%0d lv1=%0d ovf=%b fd=%b want 0", lv0, lv1, ovf, fd);
    else n_pass++;
    rst_n = 1'b1;
    bad_tx = 0; bad_st = 0; fd_all = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 5'h1f) bad_tx++;
      if (rdy !== 5'h1f || bsy !== 5'h00 || lv1 !== 5'd0) bad_st++;
    end
    n_chk++;
    if (bad_tx != 0) $display("FAIL idle_tx: %0d cycles with tx low, want 0", bad_tx);
    else n_pass++;
    n_chk++;
    if (bad_st != 0 || fd_all != 0) $display("FAIL idle_status: bad=%0d frame_done=%0d want 0/0", bad_st, fd_all);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [9:0]  seq_bits;
    logic [43:0] want, got;
    logic [7:0]  d;
    bit ok;
    int s, i;
    sel = 0; fd_q.delete();
    seq_bits = 10'b11_0100_1010;  // bit k = k-th sample: 0,1,0,1,0,0,1,0,1,1
    for (int c = 0; c < 44; c++) want[c] = (c < 40) ? seq_bits[c / 4] : 1'b1;
    wr(0, 8'hA5, 1'b1);
    wr_end();
    ok = 1'b0; i = 0; s = 0; got = '0;
    while (!ok && i < 100) begin
      @(negedge clk);
      if (tx_s === 1'b0) ok = 1'b1;
      i++;
    end
    if (ok) begin
      s = cyc;
      for (int c = 0; c < 44; c++) begin
        got[c] = tx_s;
        @(negedge clk);
      end
    end
    n_chk++;
    if (!ok || got !== want) $display("FAIL single_wave: got %h want %h (start seen %0d)", got, want, ok);
    else n_pass++;
    for (int k = 0; k < 8; k++) d[k] = got[(k + 1) * 4 + 2];
    sb_check("single_data", d);
    n_chk++;
    if (fd_q.size() != 1 || fd_q[0] != s + 39) $display("FAIL single_done: pulses=%0d at %0d want 1 at %0d", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, s + 39);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [11:0] b;
    int s;
    bit ok;
    sel = 2; fd_q.delete();
    wr(2, 8'h07, 1'b1);
    wr_end();
    rx_frame(4, 11, b, s, ok);
    repeat (8) @(negedge clk);
    sb_check("even_data", b[8:1]);
    n_chk++;
    if (!ok || b[0] !== 1'b0 || b[9] !== 1'b1 || b[10] !== 1'b1) $display("FAIL even_par: start=%b par=%b stop=%b want 0/1/1", b[0], b[9], b[10]);
    else n_pass++;
    n_chk++;
    if (fd_q.size() != 1 || fd_q[0] != s + 43) $display("FAIL even_len: pulses=%0d at %0d want 1 at %0d", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, s + 43);
    else n_pass++;

    sel = 3; fd_q.delete();
    wr(3, 8'h07, 1'b1);
    wr_end();
    rx_frame(4, 12, b, s, ok);
    repeat (8) @(negedge clk);
    sb_check("odd_data", b[8:1]);
    n_chk++;
    if (!ok || b[9] !== 1'b0 || b[11:10] !== 2'b11) $display("FAIL odd_par_stop2: par=%b stops=%b want 0/11", b[9], b[11:10]);
    else n_pass++;
    n_chk++;
    if (fd_q.size() != 1 || fd_q[0] != s + 47) $display("FAIL stop2_len: pulses=%0d at %0d want 1 at %0d", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, s + 47);
    else n_pass++;
  endtask

  task automatic test_overflow();
    sel = 0; fd_q.delete();
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          if (i == 6) begin
            @(negedge clk);
            n_chk++;
            if (rdy[0] !== 1'b0 || lv0 !== 3'd4) $display("FAIL full_state: ready=%b level=%0d want 0/4", rdy[0], lv0);
            else n_pass++;
            wd = 8'd6; wv = 5'b00001;
          end else begin
            wr(0, 8'(i), 1'b1);
          end
        end
        wr_end();
        n_chk++;
        if (ovf[0] !== 1'b1 || lv0 !== 3'd4) $display("FAIL overflow_set: ovf=%b level=%0d want 1/4", ovf[0], lv0);
        else n_pass++;
      end
      begin
        logic [11:0] b;
        int s;
        bit ok;
        for (int f = 0; f < 5; f++) begin
          rx_frame(4, 10, b, s, ok);
          n_chk++;
          if (!ok || b[0] !== 1'b0 || b[9] !== 1'b1) $display("FAIL ovf_frame%0d: found=%0d start=%b stop=%b", f, ok, b[0], b[9]);
          else n_pass++;
          sb_check("ovf_data", b[8:1]);
        end
      end
    join
    repeat (10) @(negedge clk);
    n_chk++;
    if (ovf[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || lv0 !== 3'd0) $display("FAIL ovf_drain: ovf=%b ready=%b busy=%b level=%0d want 1/1/0/0", ovf[0], rdy[0], bsy[0], lv0);
    else n_pass++;
    ovc = 1'b1;
    @(negedge clk);
    ovc = 1'b0;
    n_chk++;
    if (ovf[0] !== 1'b0) $display("FAIL ovf_clear: ovf=%b want 0", ovf[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int st[3];
    sel = 1; fd_q.delete();
    fork
      begin
        wr(1, 8'h48, 1'b1);
        wr(1, 8'h69, 1'b1);
        wr(1, 8'h0A, 1'b1);
        wr_end();
      end
      begin
        logic [11:0] b;
        bit ok;
        for (int f = 0; f < 3; f++) begin
          rx_frame(868, 10, b, st[f], ok);
          n_chk++;
          if (!ok || b[0] !== 1'b0 || b[9] !== 1'b1) $display("FAIL b2b_frame%0d: found=%0d start=%b stop=%b", f, ok, b[0], b[9]);
          else n_pass++;
          sb_check("b2b_data", b[8:1]);
        end
      end
    join
    repeat (500) @(negedge clk);
    n_chk++;
    if (st[1] - st[0] != 8680 || st[2] - st[1] != 8680) $display("FAIL b2b_gap: starts %0d,%0d,%0d want 8680 apart", st[0], st[1], st[2]);
    else n_pass++;
    n_chk++;
    if (fd_q.size() != 3 || fd_q[0] != st[0] + 8679 || fd_q[1] != st[0] + 2 * 8680 - 1 || fd_q[2] != st[0] + 3 * 8680 - 1)
      $display("FAIL b2b_done: pulses=%0d first=%0d want 3 from %0d spaced 8680", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, st[0] + 8679);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int i, bad;
    sel = 4;
    wr(4, 8'h00, 1'b0);
    wr(4, 8'hFF, 1'b0);
    wr_end();
    ok = 1'b0; i = 0;
    while (!ok && i < 100) begin
      if (tx_s === 1'b0) ok = 1'b1;
      else begin @(negedge clk); i++; end
    end
    repeat (36) @(negedge clk);  // middle of data bit 3
    n_chk++;
    if (!ok || tx[4] !== 1'b0 || lv4 !== 5'd1) $display("FAIL mid_pre: found=%0d tx=%b level=%0d want 1/0/1", ok, tx[4], lv4);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (tx[4] !== 1'b1 || lv4 !== 5'd0 || bsy[4] !== 1'b0) $display("FAIL mid_reset: tx=%b level=%0d busy=%b want 1/0/0", tx[4], lv4, bsy[4]);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0; fd_all = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx[4] !== 1'b1 || lv4 !== 5'd0) bad++;
    end
    n_chk++;
    if (bad != 0 || fd_all != 0) $display("FAIL mid_after: bad=%0d frame_done=%0d want 0/0", bad, fd_all);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d bytes never seen, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
